// File: rtl/demux_striping_pkg.sv
// ---------------------------------------------------------------------------
// demux_striping_pkg
// Shared two-lane PHY definitions used by both the transmit striping mux and
// the receive-side un-striper.
//   state_t    : lane-slot tracker encoding (EXPECT0 = next word is lane 0,
//                EXPECT1 = next word is lane 1)
//   LANE_WIDTH : default lane / stream word width
// ---------------------------------------------------------------------------
package demux_striping_pkg;

    localparam int LANE_WIDTH = 32;

    typedef enum logic {
        EXPECT0 = 1'b0,
        EXPECT1 = 1'b1
    } state_t;

endpackage : demux_striping_pkg

// File: rtl/demux_striping_hold_timer.sv
// ---------------------------------------------------------------------------
// striping_hold_timer
// Loadable down-counter that stretches a one-cycle publish strobe into a
// HOLD_CYCLES-long valid window. A load while the window is open restarts it.
// Ports:
//   clk_2f  in  1  stream clock, rising edge
//   reset   in  1  asynchronous, active-low reset
//   load    in  1  publish strobe; loads the counter with HOLD_CYCLES
//   active  out 1  high while the counter is non-zero
// ---------------------------------------------------------------------------
module striping_hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk_2f,
    input  logic reset,
    input  logic load,
    output logic active
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    logic [TW-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(HOLD_CYCLES);
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign active = (count != '0);

endmodule : striping_hold_timer

// File: rtl/demux_striping.sv
// ---------------------------------------------------------------------------
// demux_striping
// Receive-side un-striper for a two-lane PHY. Words on the 2f stream alternate
// lane 0, lane 1, lane 0, ...; the first valid word after any gap is lane 0.
// Each lane-0/lane-1 pair is published on both lane outputs in the same cycle
// and held valid for one f-period so the f-domain logic samples aligned words.
// A lane-0 word followed by a gap is published alone (orphan) and counted.
// Ports:
//   clk_2f      in  1      stream clock (2x lane rate), rising edge
//   reset       in  1      asynchronous, active-low reset
//   data_input  in  WIDTH  striped word stream
//   valid_in    in  1      data_input carries a word this cycle
//   lane_0      out WIDTH  lane-0 word, held between publishes
//   lane_1      out WIDTH  lane-1 word, held between publishes
//   valid_0     out 1      lane_0 valid, HOLD_CYCLES per publish
//   valid_1     out 1      lane_1 valid, HOLD_CYCLES per pair publish
//   orphan_cnt  out CNT_W  saturating count of lane-0 words with no partner
// ---------------------------------------------------------------------------
module demux_striping
    import demux_striping_pkg::*;
#(
    parameter int WIDTH       = LANE_WIDTH,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_input,
    input  logic             valid_in,
    output logic [WIDTH-1:0] lane_0,
    output logic [WIDTH-1:0] lane_1,
    output logic             valid_0,
    output logic             valid_1,
    output logic [CNT_W-1:0] orphan_cnt
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] stage;
    logic             publish;
    logic             pair;
    logic             pair_q;     // last publish carried a lane-1 word
    logic             hold_active;

    // Next-state / publish decode.
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        publish    = 1'b0;
        pair       = 1'b0;
        unique case (state)
            EXPECT0: begin
                if (valid_in) begin
                    state_next = EXPECT1;
                end
            end
            EXPECT1: begin
                // Lane 1 present -> pair; gap -> orphan. Either way the slot
                // resets so the next valid word is treated as lane 0.
                publish    = 1'b1;
                pair       = valid_in;
                state_next = EXPECT0;
            end
            default: state_next = EXPECT0;
        endcase
    end

    // NOTE: the stage and lane registers are reset too, so nothing undefined
    // can ever reach the outputs, even a word staged before reset.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state      <= EXPECT0;
            stage      <= '0;
            lane_0     <= '0;
            lane_1     <= '0;
            pair_q     <= 1'b0;
            orphan_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == EXPECT0 && valid_in) begin
                stage <= data_input;
            end
            if (publish) begin
                lane_0 <= stage;
                pair_q <= pair;
                if (pair) begin
                    lane_1 <= data_input;
                end else if (orphan_cnt != '1) begin
                    orphan_cnt <= orphan_cnt + CNT_W'(1);
                end
            end
        end
    end

    striping_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (publish),
        .active (hold_active)
    );

    // Valids come straight from registered state, so reset clears them at once.
    assign valid_0 = hold_active;
    assign valid_1 = hold_active & pair_q;

endmodule : demux_striping

// File: tb/tb_demux_striping.sv
// ---------------------------------------------------------------------------
// tb_demux_striping
// Directed, table-driven bench for demux_striping: reset/idle, single pair,
// streaming, orphan, counter saturation and asynchronous mid-operation reset.
// ---------------------------------------------------------------------------
module tb_demux_striping;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk_2f = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_input;
    logic             valid_in;
    logic [WIDTH-1:0] lane_0;
    logic [WIDTH-1:0] lane_1;
    logic             valid_0;
    logic             valid_1;
    logic [CNT_W-1:0] orphan_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             vin;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] l0;
        logic [WIDTH-1:0] l1;
        logic             v0;
        logic             v1;
        logic [CNT_W-1:0] oc;
    } vec_t;

    vec_t vq[$];

    always #5 clk_2f = ~clk_2f;

    demux_striping #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_input (data_input),
        .valid_in   (valid_in),
        .lane_0     (lane_0),
        .lane_1     (lane_1),
        .valid_0    (valid_0),
        .valid_1    (valid_1),
        .orphan_cnt (orphan_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] l0,
                              input logic [WIDTH-1:0] l1, input logic v0,
                              input logic v1, input logic [CNT_W-1:0] oc);
        check({tag, " lane_0"},     64'(lane_0),     64'(l0));
        check({tag, " lane_1"},     64'(lane_1),     64'(l1));
        check({tag, " valid_0"},    64'(valid_0),    64'(v0));
        check({tag, " valid_1"},    64'(valid_1),    64'(v1));
        check({tag, " orphan_cnt"}, 64'(orphan_cnt), 64'(oc));
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs are sampled
    // at that same point, i.e. showing the result of the edge just taken.
    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    // vin/d are applied before the edge; l0..oc are expected right after it.
    task automatic add_vec(input logic vin, input logic [WIDTH-1:0] d,
                           input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                           input logic v0, input logic v1, input logic [CNT_W-1:0] oc);
        vec_t v;
        v.vin = vin; v.d = d; v.l0 = l0; v.l1 = l1; v.v0 = v0; v.v1 = v1; v.oc = oc;
        vq.push_back(v);
    endtask

    initial begin
        int exp_oc;

        reset      = 1'b0;
        valid_in   = 1'b0;
        data_input = '0;

        // 1: reset held 3 cycles, then idle.
        repeat (3) step();
        check_outs("reset_held", '0, '0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        step();
        step();
        check_outs("idle", '0, '0, 1'b0, 1'b0, '0);

        // 2: single pair, 2-cycle hold, lanes retained.
        add_vec(1, 32'hAAAA_0000, 32'h0,         32'h0,         0, 0, 0);
        add_vec(1, 32'hBBBB_1111, 32'hAAAA_0000, 32'hBBBB_1111, 1, 1, 0);
        add_vec(0, 32'h0,         32'hAAAA_0000, 32'hBBBB_1111, 1, 1, 0);
        add_vec(0, 32'h0,         32'hAAAA_0000, 32'hBBBB_1111, 0, 0, 0);
        add_vec(0, 32'h0,         32'hAAAA_0000, 32'hBBBB_1111, 0, 0, 0);
        // 3: streaming words 0..7, valids continuous; garbage data while idle.
        add_vec(1, 32'd0,         32'hAAAA_0000, 32'hBBBB_1111, 0, 0, 0);
        add_vec(1, 32'd1,         32'd0,         32'd1,         1, 1, 0);
        add_vec(1, 32'd2,         32'd0,         32'd1,         1, 1, 0);
        add_vec(1, 32'd3,         32'd2,         32'd3,         1, 1, 0);
        add_vec(1, 32'd4,         32'd2,         32'd3,         1, 1, 0);
        add_vec(1, 32'd5,         32'd4,         32'd5,         1, 1, 0);
        add_vec(1, 32'd6,         32'd4,         32'd5,         1, 1, 0);
        add_vec(1, 32'd7,         32'd6,         32'd7,         1, 1, 0);
        add_vec(0, 32'hDEAD_BEEF, 32'd6,         32'd7,         1, 1, 0);
        add_vec(0, 32'hDEAD_BEEF, 32'd6,         32'd7,         0, 0, 0);
        // 4: orphan, lane_1 untouched, then the next word lands on lane 0.
        add_vec(1, 32'h1234_5678, 32'd6,         32'd7,         0, 0, 0);
        add_vec(0, 32'hDEAD_BEEF, 32'h1234_5678, 32'd7,         1, 0, 1);
        add_vec(0, 32'h0,         32'h1234_5678, 32'd7,         1, 0, 1);
        add_vec(0, 32'h0,         32'h1234_5678, 32'd7,         0, 0, 1);
        add_vec(1, 32'hCAFE_0001, 32'h1234_5678, 32'd7,         0, 0, 1);
        add_vec(1, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0002, 1, 1, 1);
        add_vec(0, 32'h0,         32'hCAFE_0001, 32'hCAFE_0002, 1, 1, 1);
        add_vec(0, 32'h0,         32'hCAFE_0001, 32'hCAFE_0002, 0, 0, 1);

        foreach (vq[i]) begin
            valid_in   = vq[i].vin;
            data_input = vq[i].d;
            step();
            check_outs($sformatf("vec%0d", i), vq[i].l0, vq[i].l1, vq[i].v0, vq[i].v1, vq[i].oc);
        end

        // 5: 300 further orphans; counter saturates at 0xFF.
        exp_oc = 1;
        for (int i = 0; i < 300; i++) begin
            valid_in   = 1'b1;
            data_input = 32'h5000_0000 + 32'(i);
            step();
            valid_in   = 1'b0;
            step();
            exp_oc = (exp_oc < 255) ? exp_oc + 1 : 255;
            check($sformatf("sat%0d orphan_cnt", i), 64'(orphan_cnt), 64'(exp_oc));
        end
        check("sat lane_0", 64'(lane_0), 64'(32'h5000_0000 + 32'd299));
        check("sat valid_1", 64'(valid_1), 64'd0);

        // 6: asynchronous reset between edges with a lane-0 word staged.
        valid_in   = 1'b1;
        data_input = 32'h1111_1111;
        step();
        data_input = 32'h2222_2222;
        step();
        data_input = 32'h3333_3333;
        step();
        check_outs("pre_reset", 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 8'hFF);
        valid_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", '0, '0, 1'b0, 1'b0, '0);
        #2;
        reset = 1'b1;
        valid_in   = 1'b1;
        data_input = 32'h4444_4444;
        step();
        check_outs("post_reset_cap", '0, '0, 1'b0, 1'b0, '0);
        data_input = 32'h5555_5555;
        step();
        check_outs("post_reset_pair", 32'h4444_4444, 32'h5555_5555, 1'b1, 1'b1, '0);
        valid_in = 1'b0;
        step();
        step();
        check_outs("post_reset_idle", 32'h4444_4444, 32'h5555_5555, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux_striping
